axi_sram_slave: RTL

AXI3 responder backed by a word-addressed internal memory. It is the far end of the uncached/cached data bridges: a simulation and FPGA stand-in for the SoC RAM, and a conformance target for the CPU-side AXI initiators. It runs one independent read FSM and one independent write FSM, each handling one burst at a time, with ID echo, byte strobes and FIXED/INCR/WRAP bursts of up to 16 beats.

---
 rtl/axi_sram_slave.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a 2^DEPTH_LOG2 x 32-bit word memory, with independent read and write burst FSMs.
// Latency: a read beat is valid one cycle after the AR handshake; a write response is valid one cycle after the last W beat.
// Backpressure: rdata/rid/rlast are held while rready_i is low; bvalid_o is held until bready_i; one burst per direction at a time.
//
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   ar*_i / arready_o                    read address channel (lock/cache/prot ignored)
//   rid_o rdata_o rresp_o rlast_o        read data channel, rvalid_o / rready_i handshake
//   aw*_i / awready_o                    write address channel (lock/cache/prot ignored)
//   wid_i wdata_i wstrb_i wlast_i        write data channel, wvalid_i / wready_o handshake (wid ignored)
//   bid_o bresp_o                        write response, bvalid_o / bready_i handshake
module axi_sram_slave #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // read address
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic [1:0]  arlock_i,
  input  logic [3:0]  arcache_i,
  input  logic [2:0]  arprot_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  // read data
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  // write address
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic [1:0]  awlock_i,
  input  logic [3:0]  awcache_i,
  input  logic [2:0]  awprot_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  // write data
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  // write response
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} w_state_e;

  // Upper address bits alias onto the same words; only the word index selects storage.
  logic [31:0] mem [DEPTH];

  // Sideband inputs that carry no meaning for this memory.
  logic unused_inputs;
  assign unused_inputs = ^{arlock_i, arcache_i, arprot_i, awlock_i, awcache_i, awprot_i, wid_i};

  // Address of the following beat. WRAP keeps the bits above the (len+1)<<size
  // window and lets only the bits inside it roll over.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [3:0]  len,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [31:0] inc;
    logic [31:0] wrap_mask;
    inc       = addr + (32'd1 << size);
    wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~wrap_mask) | (inc & wrap_mask);
      default: next_addr = inc;
    endcase
  endfunction

  // ---------------------------------------------------------------- read side
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_id_q,    r_id_d;
  logic [31:0] r_addr_q,  r_addr_d;
  logic [3:0]  r_len_q,   r_len_d;
  logic [2:0]  r_size_q,  r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [3:0]  r_cnt_q,   r_cnt_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [31:0] r_next_addr;

  assign r_next_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_INIT;
      r_id_q    <= 4'd0;
      r_addr_q  <= 32'd0;
      r_len_q   <= 4'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      r_cnt_q   <= 4'd0;
      rdata_q   <= 32'd0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    rlast_o   = 1'b0;
    case (r_state_q)
      R_INIT: r_state_d = R_IDLE;
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) begin
          r_id_d    = arid_i;
          r_addr_d  = araddr_i;
          r_len_d   = arlen_i;
          r_size_d  = arsize_i;
          r_burst_d = arburst_i;
          r_cnt_d   = 4'd0;
          // Memory is read before this edge's write commits, so a colliding
          // write is seen by the next burst, not this beat.
          rdata_d   = mem[araddr_i[DEPTH_LOG2+1:2]];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid_o = 1'b1;
        rlast_o  = (r_cnt_q == r_len_q);
        if (rready_i) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_next_addr;
            r_cnt_d  = r_cnt_q + 4'd1;
            rdata_d  = mem[r_next_addr[DEPTH_LOG2+1:2]];
          end
        end
      end
      default: r_state_d = R_INIT;
    endcase
  end

  assign rid_o   = r_id_q;
  assign rdata_o = rdata_q;
  assign rresp_o = 2'b00;

  // --------------------------------------------------------------- write side
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  w_id_q,    w_id_d;
  logic [31:0] w_addr_q,  w_addr_d;
  logic [3:0]  w_len_q,   w_len_d;
  logic [2:0]  w_size_q,  w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [3:0]  w_cnt_q,   w_cnt_d;
  logic        w_err_q,   w_err_d;
  logic        mem_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_INIT;
      w_id_q    <= 4'd0;
      w_addr_q  <= 32'd0;
      w_len_q   <= 4'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      w_cnt_q   <= 4'd0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    bresp_o   = 2'b00;
    case (w_state_q)
      W_INIT: w_state_d = W_IDLE;
      W_IDLE: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          w_id_d    = awid_i;
          w_addr_d  = awaddr_i;
          w_len_d   = awlen_i;
          w_size_d  = awsize_i;
          w_burst_d = awburst_i;
          w_cnt_d   = 4'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          mem_we   = 1'b1;
          w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
          w_cnt_d  = w_cnt_q + 4'd1;
          if (wlast_i != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
          // The beat count from AW ends the burst; wlast is only checked.
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        bresp_o  = w_err_q ? 2'b10 : 2'b00;
        if (bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_INIT;
    endcase
  end

  assign bid_o = w_id_q;

  // Storage is deliberately not reset; mem_we is low in W_INIT so reset never writes.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem[w_addr_q[DEPTH_LOG2+1:2]][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule
